// File: rtl/ddd_ctrl.sv
// ddd_ctrl: arbitrates VME and automatic delay-chip program requests, drives
// the programmer through start/busy handshakes, retries failed verifies and
// aborts on timeout.
// Ports:
//   clock, gbl_reset          - system clock, synchronous active-high reset
//   vme_req/vme_delay/vme_oe  - VME request pulse and settings
//   auto_req/auto_delay/auto_oe - automatic request pulse and settings
//   ddd_start/ddd_delay/ddd_oe - programmer command (registered)
//   ddd_busy/ddd_verify_ok    - programmer status
//   ctrl_busy, done, ok, owner, retry_cnt, err_timeout, err_verify - status
module ddd_ctrl #(
  parameter int unsigned MXRETRY = 3,
  parameter int unsigned MXTMO   = 10
) (
  input  logic        clock,
  input  logic        gbl_reset,
  input  logic        vme_req,
  input  logic [15:0] vme_delay,
  input  logic [3:0]  vme_oe,
  input  logic        auto_req,
  input  logic [15:0] auto_delay,
  input  logic [3:0]  auto_oe,
  output logic        ddd_start,
  output logic [15:0] ddd_delay,
  output logic [3:0]  ddd_oe,
  input  logic        ddd_busy,
  input  logic        ddd_verify_ok,
  output logic        ctrl_busy,
  output logic        done,
  output logic        ok,
  output logic        owner,
  output logic [1:0]  retry_cnt,
  output logic        err_timeout,
  output logic        err_verify
);

  localparam int unsigned RW = 2;
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MXRETRY);
  // Last in-window count: expiry lands DONE exactly 2**MXTMO-1 cycles after START entry.
  localparam logic [MXTMO-1:0] TMO_LAST  = MXTMO'((2**MXTMO) - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START, S_RUN, S_CHECK, S_DONE
  } state_e;

  state_e            state_q;
  logic              vme_pend_q, auto_pend_q;
  logic              vme_pend_d, auto_pend_d;
  logic              sel_q;
  logic              last_q;
  logic [MXTMO-1:0]  tmo_q;
  logic              tmo_exp;
  logic              pick;
  logic              ddd_start_q, ctrl_busy_q, done_q, ok_q, owner_q;
  logic              err_timeout_q, err_verify_q;
  logic [RW-1:0]     retry_q;
  logic [15:0]       ddd_delay_q;
  logic [3:0]        ddd_oe_q;

  // A new pulse always wins over the grant-time clear so a request made while
  // being served is queued again.
  always_comb begin
    vme_pend_d  = vme_req  | (vme_pend_q  & ~((state_q == S_GRANT) & ~sel_q));
    auto_pend_d = auto_req | (auto_pend_q & ~((state_q == S_GRANT) &  sel_q));
  end

  // Round-robin: on a tie, grant whoever was not the last owner.
  assign pick    = auto_pend_q & (~vme_pend_q | ~last_q);
  assign tmo_exp = (tmo_q == TMO_LAST);

  // Controller FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (gbl_reset) begin
      state_q       <= S_IDLE;
      vme_pend_q    <= 1'b0;
      auto_pend_q   <= 1'b0;
      sel_q         <= 1'b0;
      last_q        <= 1'b1;
      tmo_q         <= '0;
      ddd_start_q   <= 1'b0;
      ctrl_busy_q   <= 1'b0;
      done_q        <= 1'b0;
      ok_q          <= 1'b0;
      owner_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      err_verify_q  <= 1'b0;
      retry_q       <= '0;
      ddd_delay_q   <= 16'h0;
      ddd_oe_q      <= 4'h0;
    end else begin
      vme_pend_q  <= vme_pend_d;
      auto_pend_q <= auto_pend_d;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (vme_pend_q || auto_pend_q) begin
            sel_q       <= pick;
            ctrl_busy_q <= 1'b1;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          owner_q     <= sel_q;
          last_q      <= sel_q;
          ddd_delay_q <= sel_q ? auto_delay : vme_delay;
          ddd_oe_q    <= sel_q ? auto_oe : vme_oe;
          retry_q     <= '0;
          tmo_q       <= '0;
          ddd_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          if (ddd_busy) begin
            ddd_start_q <= 1'b0;
            tmo_q       <= tmo_q + MXTMO'(1);
            state_q     <= S_RUN;
          end else if (tmo_exp) begin
            ddd_start_q   <= 1'b0;
            done_q        <= 1'b1;
            ok_q          <= 1'b0;
            err_timeout_q <= 1'b1;
            err_verify_q  <= 1'b0;
            state_q       <= S_DONE;
          end else begin
            tmo_q <= tmo_q + MXTMO'(1);
          end
        end
        S_RUN: begin
          if (!ddd_busy) begin
            state_q <= S_CHECK;
          end else if (tmo_exp) begin
            done_q        <= 1'b1;
            ok_q          <= 1'b0;
            err_timeout_q <= 1'b1;
            err_verify_q  <= 1'b0;
            state_q       <= S_DONE;
          end else begin
            tmo_q <= tmo_q + MXTMO'(1);
          end
        end
        S_CHECK: begin
          if (ddd_verify_ok) begin
            done_q        <= 1'b1;
            ok_q          <= 1'b1;
            err_timeout_q <= 1'b0;
            err_verify_q  <= 1'b0;
            state_q       <= S_DONE;
          end else if (retry_q < RETRY_MAX) begin
            retry_q     <= retry_q + RW'(1);
            tmo_q       <= '0;
            ddd_start_q <= 1'b1;
            state_q     <= S_START;
          end else begin
            done_q        <= 1'b1;
            ok_q          <= 1'b0;
            err_timeout_q <= 1'b0;
            err_verify_q  <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          ctrl_busy_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          ddd_start_q <= 1'b0;
          ctrl_busy_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign ddd_start   = ddd_start_q;
  assign ddd_delay   = ddd_delay_q;
  assign ddd_oe      = ddd_oe_q;
  assign ctrl_busy   = ctrl_busy_q;
  assign done        = done_q;
  assign ok          = ok_q;
  assign owner       = owner_q;
  assign retry_cnt   = retry_q;
  assign err_timeout = err_timeout_q;
  assign err_verify  = err_verify_q;

endmodule

// File: tb/tb_ddd_ctrl.sv
// tb_ddd_ctrl: drives ddd_ctrl against a behavioural programmer and checks
// each completed operation against outcomes derived from the request rules.
module tb_ddd_ctrl;

  logic        clock = 1'b0;
  logic        gbl_reset = 1'b1;
  logic        vme_req = 1'b0, auto_req = 1'b0;
  logic [15:0] vme_delay = 16'h0, auto_delay = 16'h0;
  logic [3:0]  vme_oe = 4'h0, auto_oe = 4'h0;
  logic        ddd_start, ddd_busy, ddd_verify_ok;
  logic [15:0] ddd_delay;
  logic [3:0]  ddd_oe;
  logic        ctrl_busy, done, ok, owner, err_timeout, err_verify;
  logic [1:0]  retry_cnt;

  ddd_ctrl #(.MXRETRY(3), .MXTMO(10)) dut (
    .clock(clock), .gbl_reset(gbl_reset),
    .vme_req(vme_req), .vme_delay(vme_delay), .vme_oe(vme_oe),
    .auto_req(auto_req), .auto_delay(auto_delay), .auto_oe(auto_oe),
    .ddd_start(ddd_start), .ddd_delay(ddd_delay), .ddd_oe(ddd_oe),
    .ddd_busy(ddd_busy), .ddd_verify_ok(ddd_verify_ok),
    .ctrl_busy(ctrl_busy), .done(done), .ok(ok), .owner(owner),
    .retry_cnt(retry_cnt), .err_timeout(err_timeout), .err_verify(err_verify)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Programmer model knobs, written only by the main sequence.
  int  fails = 0;
  int  dly = 2;
  int  len = 3;
  bit  stuck = 1'b0;

  // Programmer model: busy 'dly' cycles after start, held for 'len' cycles;
  // the first 'fails' attempts of an operation read back bad.
  initial begin
    int phase = 0;
    int cnt = 0;
    int attempt = 0;
    ddd_busy = 1'b0;
    ddd_verify_ok = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!ctrl_busy) begin
        phase = 0; ddd_busy = 1'b0; attempt = 0;
      end else begin
        case (phase)
          0: if (ddd_start && !stuck) begin phase = 1; cnt = dly; end
          1: begin
            cnt--;
            if (cnt <= 0) begin ddd_busy = 1'b1; phase = 2; cnt = len; end
          end
          default: begin
            cnt--;
            if (cnt <= 0) begin
              ddd_busy = 1'b0;
              ddd_verify_ok = (attempt >= fails);
              attempt++;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  typedef struct {
    logic        ok, et, ev, own, st;
    logic [1:0]  rc;
    logic [15:0] dl;
    logic [3:0]  oe;
    int          starts;
    int          lat;
    bit          dchg;
  } rec_t;

  rec_t q[$];

  // Monitor: count start pulses per operation and log each done.
  initial begin
    bit prev_start = 1'b0;
    int starts = 0;
    int cyc = 0;
    int rise_cyc = 0;
    bit dchg = 1'b0;
    logic [15:0] first_dl = 16'h0;
    rec_t r;
    forever begin
      @(negedge clock);
      if (gbl_reset || !ctrl_busy) begin starts = 0; dchg = 1'b0; end
      if (ddd_start && !prev_start) begin
        if (starts == 0) first_dl = ddd_delay;
        else if (ddd_delay != first_dl) dchg = 1'b1;
        starts++;
        rise_cyc = cyc;
      end
      if (done) begin
        r.ok = ok; r.et = err_timeout; r.ev = err_verify; r.own = owner;
        r.st = ddd_start; r.rc = retry_cnt; r.dl = ddd_delay; r.oe = ddd_oe;
        r.starts = starts; r.lat = cyc - rise_cyc; r.dchg = dchg;
        q.push_back(r);
      end
      prev_start = ddd_start;
      cyc++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic v, input logic a);
    @(posedge clock); #1;
    vme_req = v; auto_req = a;
    @(posedge clock); #1;
    vme_req = 1'b0; auto_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output rec_t r);
    int n = 0;
    while (q.size() == 0 && n < 3000) begin @(posedge clock); n++; end
    #1;
    chk({tag, "_arrived"}, q.size() > 0, 1);
    if (q.size() > 0) r = q.pop_front();
    else r = '{default: 0};
  endtask

  // Reset with coincident requests, which must be dropped.
  task automatic do_reset();
    @(posedge clock); #1;
    gbl_reset = 1'b1; vme_req = 1'b1; auto_req = 1'b1;
    @(posedge clock); #1;
    vme_req = 1'b0; auto_req = 1'b0;
    @(posedge clock); #1;
    gbl_reset = 1'b0;
    cycles(5);
    q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clock);
    chk({tag, "_outs"}, {ddd_start, ctrl_busy, done, ok, owner, retry_cnt,
                         err_timeout, err_verify, ddd_delay, ddd_oe}, 32'h0);
  endtask

  // Outcome of one operation derived from the number of bad readbacks.
  task automatic chk_op(input string tag, input rec_t r, input logic own,
                        input logic [15:0] dl, input logic [3:0] oe, input int f);
    int used;
    used = (f < 3) ? f : 3;
    chk({tag, "_owner"}, r.own, own);
    chk({tag, "_delay"}, r.dl, dl);
    chk({tag, "_oe"}, r.oe, oe);
    chk({tag, "_flags"}, {r.ok, r.et, r.ev}, {f <= 3, 1'b0, f > 3});
    chk({tag, "_retry"}, r.rc, used);
    chk({tag, "_starts"}, r.starts, used + 1);
    chk({tag, "_dstable"}, r.dchg, 0);
  endtask

  rec_t r;
  bit   last_own;

  initial begin
    cycles(3);
    gbl_reset = 1'b0;
    do_reset();
    chk_idle_outputs("reset");

    // Single VME program, verify passes.
    vme_delay = 16'h4321; vme_oe = 4'hF; fails = 0; dly = 2; len = 3;
    pulse(1'b1, 1'b0);
    wait_done("basic", r);
    chk_op("basic", r, 1'b0, 16'h4321, 4'hF, 0);
    cycles(3);
    chk("basic_idle", ctrl_busy, 0);
    chk("basic_hold_ok", ok, 1);

    // Verify never passes: retries exhaust.
    fails = 99; vme_delay = 16'h1357; vme_oe = 4'h5;
    pulse(1'b1, 1'b0);
    wait_done("vfail", r);
    chk_op("vfail", r, 1'b0, 16'h1357, 4'h5, 99);
    cycles(3);

    // One bad readback then pass.
    fails = 1; vme_delay = 16'h9ABC; vme_oe = 4'hA;
    pulse(1'b1, 1'b0);
    wait_done("retry1", r);
    chk_op("retry1", r, 1'b0, 16'h9ABC, 4'hA, 1);
    cycles(3);

    // Programmer never goes busy: timeout.
    stuck = 1'b1; fails = 0;
    pulse(1'b1, 1'b0);
    wait_done("tmo", r);
    chk("tmo_lat", r.lat, 1023);
    chk("tmo_flags", {r.ok, r.et, r.ev}, 3'b010);
    chk("tmo_start_low", r.st, 0);
    chk("tmo_starts", r.starts, 1);
    stuck = 1'b0;
    cycles(3);

    // Simultaneous requests after reset: VME first.
    do_reset();
    vme_delay = 16'hAAAA; vme_oe = 4'h3; auto_delay = 16'h5555; auto_oe = 4'hC;
    pulse(1'b1, 1'b1);
    wait_done("tie_a", r);
    chk_op("tie_a", r, 1'b0, 16'hAAAA, 4'h3, 0);
    wait_done("tie_b", r);
    chk_op("tie_b", r, 1'b1, 16'h5555, 4'hC, 0);
    cycles(10);
    chk("tie_count", q.size(), 0);

    // Auto request during VME RUN, reset during auto START.
    dly = 3; len = 4;
    pulse(1'b1, 1'b0);
    begin
      int n = 0;
      while (!ddd_busy && n < 100) begin @(posedge clock); #1; n++; end
    end
    pulse(1'b0, 1'b1);
    wait_done("mid_vme", r);
    chk("mid_vme_owner", r.own, 0);
    begin
      int n = 0;
      while (!(ddd_start && owner) && n < 100) begin @(posedge clock); #1; n++; end
      chk("mid_auto_started", ddd_start & owner, 1);
    end
    gbl_reset = 1'b1;
    @(posedge clock); #1;
    gbl_reset = 1'b0;
    chk_idle_outputs("mid_reset");
    cycles(60);
    chk("mid_no_done", q.size(), 0);
    chk("mid_stay_idle", ctrl_busy, 0);

    // Randomized operations with round-robin order model.
    last_own = 1'b1;
    for (int it = 0; it < 24; it++) begin
      int mode;
      int f;
      mode = $urandom_range(0, 2);
      f = $urandom_range(0, 5);
      fails = f;
      dly = $urandom_range(1, 6);
      len = $urandom_range(1, 6);
      vme_delay = 16'($urandom); vme_oe = 4'($urandom);
      auto_delay = 16'($urandom); auto_oe = 4'($urandom);
      pulse(mode != 1, mode != 0);
      if (mode == 2) begin
        bit first;
        first = ~last_own;
        wait_done("rnd_first", r);
        chk_op("rnd_first", r, first, first ? auto_delay : vme_delay,
               first ? auto_oe : vme_oe, f);
        wait_done("rnd_second", r);
        chk_op("rnd_second", r, ~first, first ? vme_delay : auto_delay,
               first ? vme_oe : auto_oe, f);
        last_own = ~first;
      end else begin
        bit who;
        who = (mode == 1);
        wait_done("rnd_single", r);
        chk_op("rnd_single", r, who, who ? auto_delay : vme_delay,
               who ? auto_oe : vme_oe, f);
        last_own = who;
      end
      cycles(3);
      chk("rnd_extra_done", q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
